// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display slice.
package score_display_pkg;

  localparam int unsigned SCORE_W_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Active-low segment codes, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-decimal nibbles decode as blank
  function automatic logic [6:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = SEG_0;
      4'd1:    digit_code = SEG_1;
      4'd2:    digit_code = SEG_2;
      4'd3:    digit_code = SEG_3;
      4'd4:    digit_code = SEG_4;
      4'd5:    digit_code = SEG_5;
      4'd6:    digit_code = SEG_6;
      4'd7:    digit_code = SEG_7;
      4'd8:    digit_code = SEG_8;
      4'd9:    digit_code = SEG_9;
      default: digit_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/score_display_seg7_decode.sv
// One BCD digit plus blank flag to an active-low 7-segment code.
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  // Blank overrides the digit value
  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      o_seg = digit_code(i_digit);
    end
  end

endmodule

// File: rtl/score_display.sv
// Binary score to six-digit 7-segment display via sequential double-dabble.
// Displayed digits are only replaced on a completed conversion.
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned SCORE_W     = SCORE_W_DEF,
  parameter int unsigned BCD_DIGITS  = 8,
  parameter int unsigned DISP_DIGITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [SCORE_W-1:0]       score,
  input  logic                     blank_lz,
  output logic [DISP_DIGITS*7-1:0] seg,
  output logic                     busy,
  output logic                     overflow
);

  localparam int unsigned CNT_W  = $clog2(SCORE_W) + 1;
  localparam int unsigned BCD_W  = BCD_DIGITS * 4;
  localparam int unsigned DISP_W = DISP_DIGITS * 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SCORE_W-1:0]     r_shadow;
  logic [SCORE_W-1:0]     r_bin;
  logic [BCD_W-1:0]       r_bcd;
  logic [BCD_W-1:0]       w_bcd_adj;
  logic [CNT_W-1:0]       r_cnt;
  logic [DISP_W-1:0]      r_disp;
  logic                   r_busy;
  logic                   r_overflow;
  logic                   w_changed;
  logic                   w_last_step;
  logic                   w_hi_nonzero;
  logic                   w_zero_run;
  logic [DISP_DIGITS-1:0] w_blank;

  assign w_changed    = (score != r_shadow);
  assign w_last_step  = (r_cnt == CNT_LAST);
  assign w_hi_nonzero = |r_bcd[BCD_W-1:DISP_W];

  // Add-3 correction on every nibble >= 5, no carry between nibbles
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_changed) w_state_next = ST_SHIFT;
      ST_SHIFT: if (w_last_step) w_state_next = ST_LOAD;
      ST_LOAD:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Conversion datapath and display latch
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shadow   <= '0;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_disp     <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_changed) begin
            r_shadow <= score;
            r_bin    <= score;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[SCORE_W-1]};
          r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
          r_cnt <= r_cnt + 1'b1;
        end
        ST_LOAD: begin
          if (w_hi_nonzero) begin
            r_disp     <= {DISP_DIGITS{4'h9}};
            r_overflow <= 1'b1;
          end else begin
            r_disp     <= r_bcd[DISP_W-1:0];
            r_overflow <= 1'b0;
          end
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero blanking from the top digit down; digit 0 always lit
  always_comb begin
    w_blank    = '0;
    w_zero_run = blank_lz && !r_overflow;
    for (int unsigned d = DISP_DIGITS - 1; d >= 1; d--) begin
      w_zero_run = w_zero_run && (r_disp[d*4 +: 4] == 4'd0);
      w_blank[d] = w_zero_run;
    end
  end

  for (genvar g = 0; g < DISP_DIGITS; g++) begin : g_digit
    seg7_decode u_dec (
      .i_digit (r_disp[g*4 +: 4]),
      .i_blank (w_blank[g]),
      .o_seg   (seg[g*7 +: 7])
    );
  end

  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule
